// File: rtl/afifo_ctrl_pkg.sv
// Shared types and default widths for the async FIFO read-side controller.
// Holds the burst FSM encoding and statistics counter width.
package afifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int RD_DATA_WIDTH  = 16;
    localparam int RD_DEPTH_WIDTH = 10;
    localparam int STAT_W         = 16;

endpackage

// File: rtl/afifo_rd_skid2.sv
// Two-entry fall-through skid buffer absorbing the FIFO read latency.
// An incoming word is visible at the head in the cycle it arrives.
module afifo_rd_skid2 #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_occ;
    logic         w_empty;
    logic         w_write;
    logic         w_read;

    assign w_empty = (r_occ == 2'd0);
    // A word pushed and popped into an empty buffer bypasses storage
    assign w_write = i_push & ~(i_pop & w_empty);
    assign w_read  = i_pop & ~w_empty;

    assign o_valid = ~w_empty | i_push;
    assign o_occ   = r_occ;

    always_comb begin
        o_data = '0;
        if (!w_empty) begin
            o_data = r_mem[r_rptr];
        end else if (i_push) begin
            o_data = i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (w_write) begin
                r_wptr <= ~r_wptr;
            end
            if (w_read) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

endmodule

// File: rtl/afifo_rd_burst_ctrl.sv
// Read-domain burst sequencer: FIFO water level -> valid/ready stream.
// Optional statistics counters enabled by AFIFO_RD_BURST_STAT_EN.
module afifo_rd_burst_ctrl #(
    parameter int RD_DATA_WIDTH  = afifo_ctrl_pkg::RD_DATA_WIDTH,
    parameter int RD_DEPTH_WIDTH = afifo_ctrl_pkg::RD_DEPTH_WIDTH,
    parameter int BURST_W        = 8
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic [BURST_W-1:0]        cfg_burst_len,
    input  logic                      flush_req,
    output logic                      fifo_rd_en,
    input  logic [RD_DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                      fifo_rd_empty,
    input  logic [RD_DEPTH_WIDTH:0]   fifo_rd_water_level,
    output logic                      m_valid,
    output logic [RD_DATA_WIDTH-1:0]  m_data,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic                      busy,
    output logic                      burst_done
`ifdef AFIFO_RD_BURST_STAT_EN
    ,
    output logic [afifo_ctrl_pkg::STAT_W-1:0] stat_burst_cnt,
    output logic [afifo_ctrl_pkg::STAT_W-1:0] stat_stall_cnt
`endif
);

    import afifo_ctrl_pkg::*;

    localparam int CW = RD_DEPTH_WIDTH + 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_issue_cnt;
    logic [CW-1:0] w_issue_nxt;
    logic [CW-1:0] r_acc_cnt;
    logic [CW-1:0] w_acc_nxt;
    logic          r_inflight;
    logic [1:0]    w_occ;
    logic [CW-1:0] w_len_cfg;
    logic [CW-1:0] w_len;
    logic          w_start;
    logic          w_space;
    logic          w_pop;

    assign w_len_cfg = CW'(cfg_burst_len);
    assign w_len     = (fifo_rd_water_level < w_len_cfg) ?
                       fifo_rd_water_level : w_len_cfg;
    assign w_start   = (w_len_cfg != '0) &&
                       ((fifo_rd_water_level >= w_len_cfg) ||
                        (flush_req && !fifo_rd_empty));

    // Never have more words outstanding than the skid buffer can hold
    assign w_space    = (3'(w_occ) + 3'(r_inflight)) < 3'd2;
    assign fifo_rd_en = (r_state == BURST) && (r_issue_cnt != '0) &&
                        !fifo_rd_empty && w_space;

    assign w_pop      = m_valid & m_ready;
    assign m_last     = m_valid & (r_acc_cnt == CW'(1));
    assign burst_done = m_last & m_ready;
    assign busy       = (r_state != IDLE);

    afifo_rd_skid2 #(
        .W (RD_DATA_WIDTH)
    ) u_skid (
        .i_clk   (rd_clk),
        .i_rst   (rd_rst),
        .i_push  (r_inflight),
        .i_data  (fifo_rd_data),
        .i_pop   (w_pop),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_occ   (w_occ)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue_nxt = r_issue_cnt;
        w_acc_nxt   = r_acc_cnt;
        if (w_pop) begin
            w_acc_nxt = r_acc_cnt - CW'(1);
        end
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = BURST;
                    w_issue_nxt = w_len;
                    w_acc_nxt   = w_len;
                end
            end
            BURST: begin
                if (fifo_rd_en) begin
                    w_issue_nxt = r_issue_cnt - CW'(1);
                end
                if (w_issue_nxt == '0) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_acc_cnt == '0) || burst_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_acc_cnt   <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_acc_cnt   <= w_acc_nxt;
            r_inflight  <= fifo_rd_en;
        end
    end

`ifdef AFIFO_RD_BURST_STAT_EN
    logic [STAT_W-1:0] r_stat_burst;
    logic [STAT_W-1:0] r_stat_stall;
    logic              w_stall;

    assign w_stall = (r_state == BURST) && (r_issue_cnt != '0) &&
                     fifo_rd_empty;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_stat_burst <= '0;
            r_stat_stall <= '0;
        end else begin
            if (burst_done && (r_stat_burst != '1)) begin
                r_stat_burst <= r_stat_burst + STAT_W'(1);
            end
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + STAT_W'(1);
            end
        end
    end

    assign stat_burst_cnt = r_stat_burst;
    assign stat_stall_cnt = r_stat_stall;
`endif

endmodule

// File: tb/tb_afifo_rd_burst_ctrl.sv
// Directed bench for afifo_rd_burst_ctrl with a behavioural FIFO model.
// Checks burst sequencing, back-pressure, flush, empty stalls and reset.
module tb_afifo_rd_burst_ctrl;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b0;
    logic [7:0]  cfg_burst_len = 8'd0;
    logic        flush_req = 1'b0;
    logic        m_ready = 1'b0;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = 16'd0;
    logic        fifo_rd_empty;
    logic [10:0] fifo_rd_water_level;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        burst_done;
`ifdef AFIFO_RD_BURST_STAT_EN
    logic [15:0] stat_burst_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    afifo_rd_burst_ctrl dut (
        .rd_clk              (rd_clk),
        .rd_rst              (rd_rst),
        .cfg_burst_len       (cfg_burst_len),
        .flush_req           (flush_req),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .m_valid             (m_valid),
        .m_data              (m_data),
        .m_last              (m_last),
        .m_ready             (m_ready),
        .busy                (busy),
        .burst_done          (burst_done)
`ifdef AFIFO_RD_BURST_STAT_EN
        ,
        .stat_burst_cnt      (stat_burst_cnt),
        .stat_stall_cnt      (stat_stall_cnt)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: registered read data, reset together with the controller
    logic [15:0] fmem [0:511];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty = 1'b0;

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rd_ptr[8:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    assign fifo_rd_water_level = 11'(wr_ptr - rd_ptr);
    assign fifo_rd_empty       = force_empty || (wr_ptr == rd_ptr);

    task automatic push_w(input logic [15:0] v);
        fmem[wr_ptr[8:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Monitor sampled on the falling edge
    logic        clr = 1'b0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          acc_tb = 0;
    int          viol = 0;
    int          first_rd = -1;
    int          last_rd = -1;
    int          first_val = -1;
    int          last_cnt = 0;
    int          done_cnt = 0;
    int          done_viol = 0;
    int          busy_seen = 0;
    int          first_done = -1;
    int          last_done = -1;
    logic [15:0] last_data = 16'd0;
    logic [15:0] out_q [$];

    always @(negedge rd_clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            rd_cnt     <= 0;
            acc_tb     <= 0;
            viol       <= 0;
            first_rd   <= -1;
            last_rd    <= -1;
            first_val  <= -1;
            last_cnt   <= 0;
            done_cnt   <= 0;
            done_viol  <= 0;
            busy_seen  <= 0;
            first_done <= -1;
            last_done  <= -1;
            last_data  <= 16'd0;
            out_q.delete();
        end else if (!rd_rst) begin
            if (fifo_rd_en) begin
                if (rd_cnt - acc_tb >= 2) viol <= viol + 1;
                if (first_rd < 0) first_rd <= cyc;
                last_rd <= cyc;
                rd_cnt  <= rd_cnt + 1;
            end
            if (m_valid && first_val < 0) first_val <= cyc;
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                acc_tb <= acc_tb + 1;
                if (m_last) begin
                    last_cnt  <= last_cnt + 1;
                    last_data <= m_data;
                end
            end
            if (burst_done != (m_valid && m_ready && m_last))
                done_viol <= done_viol + 1;
            if (burst_done) begin
                done_cnt <= done_cnt + 1;
                if (first_done < 0) first_done <= cyc;
                last_done <= cyc;
            end
            if (busy) busy_seen <= busy_seen + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [15:0] base,
                           input int n);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (out_q.size() <= i) errs++;
            else if (out_q[i] !== base + 16'(i)) errs++;
        end
        chk(tag, errs, 0);
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge rd_clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int max_cyc,
                             input bit tog, input string tag);
        int n = 0;
        while (done_cnt < target && n < max_cyc) begin
            @(posedge rd_clk);
            #1;
            if (tog) m_ready = ~m_ready;
            @(negedge rd_clk);
            #1;
            n++;
        end
        chk(tag, done_cnt, target);
    endtask

    task automatic wait_rd(input int target, input string tag);
        int n = 0;
        while (rd_cnt < target && n < 40) begin
            @(negedge rd_clk);
            #1;
            n++;
        end
        chk(tag, rd_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rd_rst = 1'b1;
        #2;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_data", m_data, 0);
        repeat (3) @(posedge rd_clk);
        #1 rd_rst = 1'b0;
        clear_mon();

        // Full burst of 4 with free-flowing sink
        cfg_burst_len = 8'd4;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_w(16'hA000 + 16'(i));
        wait_done(1, 40, 1'b0, "t1_done");
        chk("t1_rd_cnt", rd_cnt, 4);
        chk("t1_rd_span", last_rd - first_rd, 3);
        chk("t1_val_lat", first_val - first_rd, 1);
        chk("t1_nwords", out_q.size(), 4);
        chk_seq("t1_data", 16'hA000, 4);
        chk("t1_nlast", last_cnt, 1);
        chk("t1_last_data", last_data, 16'hA003);
        chk("t1_done_align", done_viol, 0);
        @(negedge rd_clk);
        #1;
        chk("t1_busy_after", busy, 0);

        // Burst of 8 with toggling ready
        clear_mon();
        cfg_burst_len = 8'd8;
        for (int i = 0; i < 8; i++) push_w(16'hB000 + 16'(i));
        wait_done(1, 80, 1'b1, "t2_done");
        m_ready = 1'b1;
        chk("t2_overissue", viol, 0);
        chk("t2_nwords", out_q.size(), 8);
        chk_seq("t2_data", 16'hB000, 8);
        chk("t2_nlast", last_cnt, 1);
        chk("t2_done_align", done_viol, 0);
        step();
        step();

        // Partial flush: level 3 under a length of 4
        clear_mon();
        cfg_burst_len = 8'd4;
        flush_req = 1'b1;
        for (int i = 0; i < 3; i++) push_w(16'hC000 + 16'(i));
        wait_done(1, 40, 1'b0, "t3_done");
        flush_req = 1'b0;
        chk("t3_rd_cnt", rd_cnt, 3);
        chk_seq("t3_data", 16'hC000, 3);
        chk("t3_nlast", last_cnt, 1);
        chk("t3_last_data", last_data, 16'hC002);
        @(negedge rd_clk);
        #1;
        chk("t3_busy_after", busy, 0);

        // Empty forced for 5 cycles after two reads
        clear_mon();
        for (int i = 0; i < 4; i++) push_w(16'hD000 + 16'(i));
        wait_rd(2, "t4_two_reads");
        begin
            int stall_rd = 0;
            @(posedge rd_clk);
            #1 force_empty = 1'b1;
            repeat (5) begin
                @(negedge rd_clk);
                #1;
                if (fifo_rd_en) stall_rd++;
            end
            chk("t4_stall_rd", stall_rd, 0);
            chk("t4_rd_hold", rd_cnt, 2);
            @(posedge rd_clk);
            #1 force_empty = 1'b0;
        end
        wait_done(1, 40, 1'b0, "t4_done");
        chk("t4_rd_cnt", rd_cnt, 4);
        chk_seq("t4_data", 16'hD000, 4);
        chk("t4_nlast", last_cnt, 1);
`ifdef AFIFO_RD_BURST_STAT_EN
        chk("t4_stat_stall", stat_stall_cnt, 5);
        chk("t4_stat_burst", stat_burst_cnt, 4);
`endif
        step();

        // Reset while the skid buffer is full
        clear_mon();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_w(16'hE000 + 16'(i));
        wait_rd(2, "t5_two_reads");
        @(negedge rd_clk);
        @(negedge rd_clk);
        #1;
        chk("t5_pre_valid", m_valid, 1);
        chk("t5_pre_rd_cnt", rd_cnt, 2);
        chk("t5_pre_data", m_data, 16'hE000);
        rd_rst = 1'b1;
        #1;
        chk("t5_rst_valid", m_valid, 0);
        chk("t5_rst_rd_en", fifo_rd_en, 0);
        chk("t5_rst_busy", busy, 0);
        step();
        step();
        rd_rst = 1'b0;
`ifdef AFIFO_RD_BURST_STAT_EN
        chk("t5_stat_clr", stat_burst_cnt, 0);
`endif
        clear_mon();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_w(16'hF000 + 16'(i));
        wait_done(1, 40, 1'b0, "t5_done");
        chk("t5_rd_cnt", rd_cnt, 4);
        chk_seq("t5_data", 16'hF000, 4);
        chk("t5_nlast", last_cnt, 1);
        step();

        // Zero length blocks bursts, then back-to-back pairs
        clear_mon();
        cfg_burst_len = 8'd0;
        for (int i = 0; i < 100; i++) push_w(16'h1000 + 16'(i));
        repeat (20) step();
        chk("t6_no_rd", rd_cnt, 0);
        chk("t6_no_busy", busy_seen, 0);
        cfg_burst_len = 8'd2;
        wait_done(5, 60, 1'b0, "t6_done");
        cfg_burst_len = 8'd0;
        chk_seq("t6_data", 16'h1000, 10);
        chk("t6_nlast", last_cnt, 5);
        chk("t6_period", last_done - first_done, 16);
        chk("t6_overissue", viol, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
